// File: rtl/sd_init_seq_if.sv
// Handshake bundle between the SD init sequencer (master) and the SD command engine (slave).
// The master issues commands and the clock divider; the slave reports status and responses.
interface sd_init_seq_if;
  logic        start;
  logic [15:0] clkdiv;
  logic [15:0] precnt;
  logic [5:0]  cmd;
  logic [31:0] arg;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        syntaxe;
  logic [31:0] resparg;

  modport master (
    output start, clkdiv, precnt, cmd, arg,
    input  busy, done, timeout, syntaxe, resparg
  );

  modport slave (
    input  start, clkdiv, precnt, cmd, arg,
    output busy, done, timeout, syntaxe, resparg
  );
endinterface

// File: rtl/sd_init_seq.sv
// SD card identification sequencer: CMD0, CMD8, CMD55/ACMD41 polling, CMD2, CMD3, CMD7.
// Drives a command engine one command at a time and reports card type, RCA and error codes.
module sd_init_seq #(
  parameter logic [15:0] SLOWDIV      = 16'd199,
  parameter logic [15:0] FASTDIV      = 16'd1,
  parameter logic [15:0] ACMD41_RETRY = 16'd4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_init_start,
  output logic        o_init_busy,
  output logic        o_init_done,
  output logic        o_init_err,
  output logic [2:0]  o_err_code,
  output logic [1:0]  o_card_type,
  output logic [15:0] o_rca,
  sd_init_seq_if.master cmd_if
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_EVAL, S_DONE, S_ERR
  } state_t;

  typedef enum logic [2:0] {
    STEP_CMD0, STEP_CMD8, STEP_CMD55, STEP_ACMD41, STEP_CMD2, STEP_CMD3, STEP_CMD7
  } step_t;

  state_t      r_state,    w_nextState;
  step_t       r_step,     w_nextStep;
  logic        r_start,    w_nextStart;
  logic [5:0]  r_cmd,      w_nextCmd;
  logic [31:0] r_arg,      w_nextArg;
  logic [15:0] r_precnt,   w_nextPrecnt;
  logic [15:0] r_clkdiv,   w_nextClkdiv;
  logic [2:0]  r_errCode,  w_nextErrCode;
  logic [1:0]  r_cardType, w_nextCardType;
  logic [15:0] r_rca,      w_nextRca;
  logic [15:0] r_retry,    w_nextRetry;
  logic        r_v2,       w_nextV2;
  logic        w_retryEvent;
  logic        w_cmdOk;

  assign w_cmdOk = cmd_if.done && !cmd_if.timeout && !cmd_if.syntaxe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_step     <= STEP_CMD0;
      r_start    <= 1'b0;
      r_cmd      <= 6'd0;
      r_arg      <= 32'd0;
      r_precnt   <= 16'd0;
      r_clkdiv   <= SLOWDIV;
      r_errCode  <= 3'd0;
      r_cardType <= 2'd0;
      r_rca      <= 16'd0;
      r_retry    <= 16'd0;
      r_v2       <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_step     <= w_nextStep;
      r_start    <= w_nextStart;
      r_cmd      <= w_nextCmd;
      r_arg      <= w_nextArg;
      r_precnt   <= w_nextPrecnt;
      r_clkdiv   <= w_nextClkdiv;
      r_errCode  <= w_nextErrCode;
      r_cardType <= w_nextCardType;
      r_rca      <= w_nextRca;
      r_retry    <= w_nextRetry;
      r_v2       <= w_nextV2;
    end
  end

  // The command fields are latched only when a command is launched, so they stay
  // stable for the whole engine transaction; responses are judged in the done cycle.
  always_comb begin
    w_nextState    = r_state;
    w_nextStep     = r_step;
    w_nextStart    = 1'b0;
    w_nextCmd      = r_cmd;
    w_nextArg      = r_arg;
    w_nextPrecnt   = r_precnt;
    w_nextClkdiv   = r_clkdiv;
    w_nextErrCode  = r_errCode;
    w_nextCardType = r_cardType;
    w_nextRca      = r_rca;
    w_nextRetry    = r_retry;
    w_nextV2       = r_v2;
    w_retryEvent   = 1'b0;

    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (i_init_start) begin
          w_nextState    = S_ISSUE;
          w_nextStep     = STEP_CMD0;
          w_nextErrCode  = 3'd0;
          w_nextCardType = 2'd0;
          w_nextRca      = 16'd0;
          w_nextClkdiv   = SLOWDIV;
          w_nextV2       = 1'b0;
        end
      end

      S_ISSUE: begin
        if (!cmd_if.busy) begin
          w_nextStart  = 1'b1;
          w_nextState  = S_WAIT;
          w_nextPrecnt = 16'd8;
          w_nextArg    = 32'd0;
          case (r_step)
            STEP_CMD0: begin
              w_nextCmd    = 6'd0;
              w_nextPrecnt = 16'd250;
            end
            STEP_CMD8: begin
              w_nextCmd = 6'd8;
              w_nextArg = 32'h0000_01AA;
            end
            STEP_CMD55:  w_nextCmd = 6'd55;
            STEP_ACMD41: begin
              w_nextCmd = 6'd41;
              w_nextArg = r_v2 ? 32'h4010_0000 : 32'h0010_0000;
            end
            STEP_CMD2:   w_nextCmd = 6'd2;
            STEP_CMD3:   w_nextCmd = 6'd3;
            STEP_CMD7: begin
              w_nextCmd = 6'd7;
              w_nextArg = {r_rca, 16'h0000};
            end
            default:     w_nextCmd = 6'd0;
          endcase
        end
      end

      S_WAIT: begin
        if (cmd_if.done) begin
          w_nextState = S_EVAL;
          case (r_step)
            STEP_CMD0: w_nextStep = STEP_CMD8;
            STEP_CMD8: begin
              w_nextRetry = ACMD41_RETRY;
              if (cmd_if.timeout) begin
                w_nextV2   = 1'b0;
                w_nextStep = STEP_CMD55;
              end else if (!cmd_if.syntaxe && cmd_if.resparg[11:0] == 12'h1AA) begin
                w_nextV2   = 1'b1;
                w_nextStep = STEP_CMD55;
              end else begin
                w_nextState   = S_ERR;
                w_nextErrCode = 3'd1;
              end
            end
            STEP_CMD55: begin
              if (w_cmdOk) w_nextStep = STEP_ACMD41;
              else         w_retryEvent = 1'b1;
            end
            STEP_ACMD41: begin
              if (w_cmdOk && cmd_if.resparg[31]) begin
                w_nextCardType = r_v2 ? (cmd_if.resparg[30] ? 2'd3 : 2'd2) : 2'd1;
                w_nextStep     = STEP_CMD2;
              end else begin
                w_retryEvent = 1'b1;
              end
            end
            STEP_CMD2: begin
              if (!cmd_if.timeout) begin
                w_nextStep = STEP_CMD3;
              end else begin
                w_nextState   = S_ERR;
                w_nextErrCode = 3'd3;
              end
            end
            STEP_CMD3: begin
              if (w_cmdOk && cmd_if.resparg[31:16] != 16'd0) begin
                w_nextRca  = cmd_if.resparg[31:16];
                w_nextStep = STEP_CMD7;
              end else begin
                w_nextState   = S_ERR;
                w_nextErrCode = 3'd4;
              end
            end
            STEP_CMD7: begin
              if (w_cmdOk) begin
                w_nextClkdiv = FASTDIV;
                w_nextState  = S_DONE;
              end else begin
                w_nextState   = S_ERR;
                w_nextErrCode = 3'd5;
              end
            end
            default: w_nextState = S_IDLE;
          endcase

          // A zero count never underflows; one means this was the last permitted attempt.
          if (w_retryEvent) begin
            if (r_retry == 16'd1) begin
              w_nextState   = S_ERR;
              w_nextErrCode = 3'd2;
            end else begin
              w_nextStep = STEP_CMD55;
              if (r_retry != 16'd0) w_nextRetry = r_retry - 16'd1;
            end
          end
        end
      end

      S_EVAL:  w_nextState = S_ISSUE;
      default: w_nextState = S_IDLE;
    endcase
  end

  assign o_init_busy = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_EVAL);
  assign o_init_done = (r_state == S_DONE);
  assign o_init_err  = (r_state == S_ERR);
  assign o_err_code  = r_errCode;
  assign o_card_type = r_cardType;
  assign o_rca       = r_rca;

  assign cmd_if.start  = r_start;
  assign cmd_if.cmd    = r_cmd;
  assign cmd_if.arg    = r_arg;
  assign cmd_if.precnt = r_precnt;
  assign cmd_if.clkdiv = r_clkdiv;

endmodule

// File: doc/sd_init_seq.md
SD_INIT_SEQ -- requirements
Module: sd_init_seq

Interface
REQ-001 Parameter SLOWDIV, default 16'd199: clkdiv value driven during identification (about 400 kHz).
REQ-002 Parameter FASTDIV, default 16'd1: clkdiv value driven after successful initialization.
REQ-003 Parameter ACMD41_RETRY, default 16'd4000: maximum failed CMD55/ACMD41 attempts.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 init_start  in  1  request to run the initialization sequence.
REQ-007 init_busy  out  1  sequence in progress.
REQ-008 init_done  out  1  level; card initialized and selected.
REQ-009 init_err  out  1  level; sequence aborted.
REQ-010 err_code  out  3  0 none, 1 CMD8, 2 ACMD41 exhausted, 3 CMD2, 4 CMD3, 5 CMD7.
REQ-011 card_type  out  2  0 unknown, 1 SDv1, 2 SDv2 standard capacity, 3 SDv2 high capacity.
REQ-012 rca  out  16  relative card address from CMD3.
REQ-013 clkdiv  out  16  to command engine.
REQ-014 start  out  1  one-cycle command request to command engine.
REQ-015 precnt  out  16  idle sdclk count before the command.
REQ-016 cmd  out  6  command index.
REQ-017 arg  out  32  command argument.
REQ-018 busy, done, timeout, syntaxe  in  1 each  command-engine status; done, timeout and syntaxe are single-cycle pulses.
REQ-019 resparg  in  32  response argument; valid in the done cycle.

Function
REQ-020 Handshake: start SHALL assert for exactly one cycle, only when busy==0; cmd, arg and precnt SHALL be stable from that cycle until done.
REQ-021 After done, the block SHALL wait for busy==0 before the next start; no start while busy==1.
REQ-022 States: IDLE, ISSUE, WAIT, EVAL, DONE, ERR; step sub-state in {CMD0, CMD8, CMD55, ACMD41, CMD2, CMD3, CMD7}; each step runs ISSUE -> WAIT(done) -> evaluation in the done cycle.
REQ-023 init_start in IDLE, DONE or ERR SHALL clear init_done, init_err, err_code, card_type and rca, set clkdiv=SLOWDIV, assert init_busy, and begin CMD0; init_start is ignored while init_busy==1.
REQ-024 CMD0: cmd=0, arg=0, precnt=16'd250; any done (timeout included) -> CMD8.
REQ-025 CMD8: cmd=8, arg=32'h000001AA, precnt=8; timeout -> v2=0, go to CMD55; no timeout, no syntaxe and resparg[11:0]==12'h1AA -> v2=1, go to CMD55; otherwise ERR, code 1.
REQ-026 On leaving CMD8, the 16-bit retry counter SHALL load ACMD41_RETRY.
REQ-027 CMD55: cmd=55, arg=0, precnt=8; success (no timeout, no syntaxe) -> ACMD41; failure -> retry handling.
REQ-028 ACMD41: cmd=41, arg=v2 ? 32'h40100000 : 32'h00100000, precnt=8; success with resparg[31]==1 -> card_type = v2 ? (resparg[30] ? 3 : 2) : 1, go to CMD2; otherwise retry handling.
REQ-029 Retry handling: if retry==1 -> ERR, code 2; else retry decrements and the sequence returns to CMD55; retry never wraps below 0.
REQ-030 CMD2: cmd=2, arg=0, precnt=8; no timeout -> CMD3 (syntaxe ignored, R2 is long); timeout -> ERR, code 3.
REQ-031 CMD3: cmd=3, arg=0, precnt=8; success with resparg[31:16]!=0 -> rca=resparg[31:16], go to CMD7; otherwise ERR, code 4.
REQ-032 CMD7: cmd=7, arg={rca,16'h0000}, precnt=8; success -> clkdiv=FASTDIV, DONE; otherwise ERR, code 5.
REQ-033 DONE: init_done=1, init_busy=0. ERR: init_err=1, init_busy=0, card_type held. Both are held until the next init_start.
REQ-034 done and init_start in the same cycle while busy: done is processed and init_start is ignored.

Reset
REQ-035 During rst_n==0: start=0, cmd=0, arg=0, precnt=0, clkdiv=SLOWDIV, init_busy=0, init_done=0, init_err=0, err_code=0, card_type=0, rca=0, retry=0, state IDLE.
REQ-036 Reset asserted mid-sequence SHALL abort immediately; no start is emitted until a new init_start after release.

Verification
REQ-037 SDHC path: CMD8 echo 0x1AA, ACMD41 returns 32'hC0FF8000 on the 3rd try, CMD3 returns 32'h12340000 -> card_type=3, rca=16'h1234, CMD7 arg=32'h12340000, clkdiv=FASTDIV, init_done=1.
REQ-038 SDv1: CMD8 timeout, ACMD41 returns 32'h80FF8000 -> ACMD41 arg=32'h00100000, card_type=1, init_done=1.
REQ-039 CMD8 returns 12'h0AA -> init_err=1, err_code=1, no further start.
REQ-040 ACMD41_RETRY=3 and ACMD41 bit31 never set -> exactly 3 ACMD41 commands are issued, then err_code=2.
REQ-041 Engine model holds busy 5 cycles after done -> no start while busy==1; each start is exactly 1 cycle wide.
REQ-042 rst_n low during ACMD41 WAIT -> all outputs return to reset values; a new init_start restarts at CMD0 with precnt=250.
